// File: rtl/pipelined_control_unit.sv
// Decode-stage control unit for the 5-stage MIPS core; branch/jump resolved combinationally, controls piped E/M/W.
// Latency: decode outputs 0 cycles, _E 1, _M 2, _W 3. Backpressure: STALL_D/FLUSH_E load a bubble into ID/EX; M/W always advance.
// Optional: define BNE_EN to decode bne (opcode 000101).
module pipelined_control_unit #(
    parameter int ALUCTRL_W = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [5:0]           OPCODE,
    input  logic [5:0]           FUNCT,
    input  logic                 EQUAL_D,
    input  logic                 STALL_D,
    input  logic                 FLUSH_E,
    output logic                 PCSRC_D,
    output logic                 JUMP_D,
    output logic                 CLR_D,
    output logic                 ILLEGAL_D,
    output logic                 REGWRITE_E,
    output logic                 MEMTOREG_E,
    output logic                 MEMWRITE_E,
    output logic                 ALUSRC_E,
    output logic                 REGDST_E,
    output logic [ALUCTRL_W-1:0] ALUCONTROL_E,
    output logic                 REGWRITE_M,
    output logic                 MEMTOREG_M,
    output logic                 MEMWRITE_M,
    output logic                 REGWRITE_W,
    output logic                 MEMTOREG_W
);

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regdst;
        logic [2:0] aluctrl;
    } ex_ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } mem_ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wb_ctrl_t;

    ex_ctrl_t  dec;
    logic      branch;
    logic      branch_ne;
    logic      jump;
    logic      illegal;
    ex_ctrl_t  id_ex;
    mem_ctrl_t ex_mem;
    wb_ctrl_t  mem_wb;

    // Illegal encodings leave every control at zero so they retire as a NOP.
    always_comb begin
        dec       = '0;
        branch    = 1'b0;
        branch_ne = 1'b0;
        jump      = 1'b0;
        illegal   = 1'b0;
        case (OPCODE)
            6'b000000: begin
                dec.regwrite = 1'b1;
                dec.regdst   = 1'b1;
                case (FUNCT)
                    6'b100000: dec.aluctrl = 3'b010;
                    6'b100010: dec.aluctrl = 3'b110;
                    6'b100100: dec.aluctrl = 3'b000;
                    6'b100101: dec.aluctrl = 3'b001;
                    6'b101010: dec.aluctrl = 3'b111;
                    default: begin
                        dec     = '0;
                        illegal = 1'b1;
                    end
                endcase
            end
            6'b100011: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.memtoreg = 1'b1;
                dec.aluctrl  = 3'b010;
            end
            6'b101011: begin
                dec.memwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.aluctrl  = 3'b010;
            end
            6'b000100: begin
                branch      = 1'b1;
                dec.aluctrl = 3'b110;
            end
            6'b001000: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.aluctrl  = 3'b010;
            end
            6'b000010: jump = 1'b1;
`ifdef BNE_EN
            6'b000101: begin
                branch_ne   = 1'b1;
                dec.aluctrl = 3'b110;
            end
`endif
            default: illegal = 1'b1;
        endcase
    end

    // A stalled branch has stale comparator operands and must not redirect.
`ifdef BNE_EN
    assign PCSRC_D = ((branch & EQUAL_D) | (branch_ne & ~EQUAL_D)) & ~STALL_D;
`else
    assign PCSRC_D = branch & EQUAL_D & ~STALL_D & ~branch_ne;
`endif
    assign JUMP_D    = jump & ~STALL_D;
    assign CLR_D     = PCSRC_D | JUMP_D;
    assign ILLEGAL_D = illegal;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            id_ex  <= (FLUSH_E || STALL_D) ? '0 : dec;
            ex_mem <= '{regwrite: id_ex.regwrite, memtoreg: id_ex.memtoreg, memwrite: id_ex.memwrite};
            mem_wb <= '{regwrite: ex_mem.regwrite, memtoreg: ex_mem.memtoreg};
        end
    end

    assign REGWRITE_E   = id_ex.regwrite;
    assign MEMTOREG_E   = id_ex.memtoreg;
    assign MEMWRITE_E   = id_ex.memwrite;
    assign ALUSRC_E     = id_ex.alusrc;
    assign REGDST_E     = id_ex.regdst;
    assign ALUCONTROL_E = ALUCTRL_W'(id_ex.aluctrl);
    assign REGWRITE_M   = ex_mem.regwrite;
    assign MEMTOREG_M   = ex_mem.memtoreg;
    assign MEMWRITE_M   = ex_mem.memwrite;
    assign REGWRITE_W   = mem_wb.regwrite;
    assign MEMTOREG_W   = mem_wb.memtoreg;

endmodule
